// File: rtl/decode_queue.sv
// decode_queue: buffered RV32I/RV64I decode stage.
// A FIFO of fetched instructions feeds a registered decoded-output slot.
module decode_queue #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int ENABLE_M = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [XLEN-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [2:0]             func3,
    output logic [6:0]             func7,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [4:0]             rd,
    output logic [XLEN-1:0]        imme,
    output logic [8:0]             itype,
    output logic                   illegal,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    localparam bit RV64 = (XLEN == 64);
    localparam bit M_EN = (ENABLE_M != 0);

    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    assign in_ready = (level < FULL) && !rst;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = (level != '0) && (!out_valid || out_ready) && !flush;

    logic [31:0]        hd;
    logic [6:0]         op;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [8:0]         cls;
    logic               bad;
    logic               sh_zero;
    logic               sh_alt;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]    dec_imm;
    logic [4:0]         dec_rs1;
    logic [4:0]         dec_rs2;

    assign hd = instr_mem[rd_ptr];
    assign op = hd[6:0];
    assign f3 = hd[14:12];
    assign f7 = hd[31:25];

    // RV64 shift amounts use bit 25, so only [31:26] must be clear
    assign sh_zero = RV64 ? (hd[31:26] == 6'b000000) : (hd[31:25] == 7'b0000000);
    assign sh_alt  = RV64 ? (hd[31:26] == 6'b010000) : (hd[31:25] == 7'b0100000);

    always_comb begin
        cls = '0;
        unique case (op)
            7'b0010011: cls[0] = 1'b1;
            7'b0000011: cls[1] = 1'b1;
            7'b0100011: cls[2] = 1'b1;
            7'b0110011: cls[3] = 1'b1;
            7'b1101111: cls[4] = 1'b1;
            7'b1100111: cls[5] = 1'b1;
            7'b0110111: cls[6] = 1'b1;
            7'b0010111: cls[7] = 1'b1;
            7'b1100011: cls[8] = 1'b1;
            default:    cls    = '0;
        endcase
    end

    always_comb begin
        bad = 1'b0;
        unique case (1'b1)
            cls[3]:  bad = !(f7 == 7'b0000000 || f7 == 7'b0100000
                             || (M_EN && f7 == 7'b0000001))
                           || (f7 == 7'b0100000 && !(f3 == 3'b000 || f3 == 3'b101));
            cls[0]:  bad = (f3 == 3'b001 && !sh_zero)
                           || (f3 == 3'b101 && !(sh_zero || sh_alt));
            cls[5]:  bad = (f3 != 3'b000);
            cls[1]:  bad = RV64 ? (f3 == 3'b111)
                                : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
            cls[2]:  bad = f3 > (RV64 ? 3'd3 : 3'd2);
            cls[8]:  bad = (f3 == 3'b010 || f3 == 3'b011);
            default: bad = (cls == '0);
        endcase
    end

    always_comb begin
        imm32 = '0;
        unique case (1'b1)
            cls[0], cls[1], cls[5]: imm32 = {{20{hd[31]}}, hd[31:20]};
            cls[2]:  imm32 = {{20{hd[31]}}, hd[31:25], hd[11:7]};
            cls[8]:  imm32 = {{19{hd[31]}}, hd[31], hd[7], hd[30:25], hd[11:8], 1'b0};
            cls[4]:  imm32 = {{11{hd[31]}}, hd[31], hd[19:12], hd[20], hd[30:21], 1'b0};
            cls[6], cls[7]: imm32 = {hd[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    assign dec_imm = XLEN'(imm32);
    assign dec_rs1 = (|{cls[0], cls[1], cls[2], cls[3], cls[5], cls[8]}) ? hd[19:15] : 5'd0;
    assign dec_rs2 = (|{cls[2], cls[3], cls[8]}) ? hd[24:20] : 5'd0;

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (!push && pop) level <= level - 1'b1;
            if (pop)            out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;
        end
    end

    // Slot fields survive flush and drain; only reset clears them
    always_ff @(posedge clk) begin
        if (rst) begin
            out_pc  <= '0;
            func3   <= '0;
            func7   <= '0;
            rs1     <= '0;
            rs2     <= '0;
            rd      <= '0;
            imme    <= '0;
            itype   <= '0;
            illegal <= 1'b0;
        end else if (pop) begin
            out_pc  <= pc_mem[rd_ptr];
            func3   <= f3;
            func7   <= f7;
            rd      <= hd[11:7];
            rs1     <= bad ? 5'd0 : dec_rs1;
            rs2     <= bad ? 5'd0 : dec_rs2;
            imme    <= bad ? '0 : dec_imm;
            itype   <= bad ? 9'd0 : cls;
            illegal <= bad;
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: scoreboard bench for decode_queue.
// Three instances share stimulus: RV32, RV32 with M, RV64.
module tb_decode_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    always #5 clk = ~clk;

    logic        in_ready, out_valid, illegal;
    logic [31:0] out_pc, imme;
    logic [2:0]  func3, level;
    logic [6:0]  func7;
    logic [4:0]  rs1, rs2, rd;
    logic [8:0]  itype;

    logic        m_in_ready, m_out_valid, m_illegal;
    logic [31:0] m_out_pc, m_imme;
    logic [2:0]  m_func3, m_level;
    logic [6:0]  m_func7;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [8:0]  m_itype;

    logic        x_in_ready, x_out_valid, x_illegal;
    logic [63:0] x_out_pc, x_imme;
    logic [2:0]  x_func3, x_level;
    logic [6:0]  x_func7;
    logic [4:0]  x_rs1, x_rs2, x_rd;
    logic [8:0]  x_itype;

    decode_queue #(.XLEN(32), .DEPTH(4), .ENABLE_M(0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .func3(func3), .func7(func7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imme(imme),
        .itype(itype), .illegal(illegal), .level(level)
    );

    decode_queue #(.XLEN(32), .DEPTH(4), .ENABLE_M(1)) dut_m (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(m_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(m_out_valid), .out_ready(out_ready),
        .out_pc(m_out_pc), .func3(m_func3), .func7(m_func7),
        .rs1(m_rs1), .rs2(m_rs2), .rd(m_rd), .imme(m_imme),
        .itype(m_itype), .illegal(m_illegal), .level(m_level)
    );

    decode_queue #(.XLEN(64), .DEPTH(4), .ENABLE_M(0)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(x_in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(x_out_valid), .out_ready(out_ready),
        .out_pc(x_out_pc), .func3(x_func3), .func7(x_func7),
        .rs1(x_rs1), .rs2(x_rs2), .rd(x_rd), .imme(x_imme),
        .itype(x_itype), .illegal(x_illegal), .level(x_level)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [8:0]  it;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  d;
        logic [31:0] im;
        logic        il;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;

    // Scoreboard: every slot consumed by execute must match the next expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            popped++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc %h, required no output", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_pc, itype, rs1, rs2, rd, imme, illegal} !== mon_e) begin
                    errors++;
                    $display("FAIL sb_slot: got pc %h it %h rs1 %0d rs2 %0d rd %0d imm %h ill %b, required pc %h it %h rs1 %0d rs2 %0d rd %0d imm %h ill %b",
                             out_pc, itype, rs1, rs2, rd, imme, illegal,
                             mon_e.pc, mon_e.it, mon_e.r1, mon_e.r2, mon_e.d, mon_e.im, mon_e.il);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; leaves in_valid high for back-to-back use
    task automatic push(input logic [31:0] ins, input logic [31:0] pc,
                        input logic [8:0] it, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] d,
                        input logic [31:0] im, input logic il);
        int n;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = {32'h0, pc};
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL push_timeout: in_ready %b, required 1", in_ready);
        end else begin
            exp_q.push_back('{pc, it, r1, r2, d, im, il});
        end
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL wait_valid: out_valid %b, required 1", out_valid);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_instr = '0;
        in_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, level} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy %b vld %b lvl %0d, required 0 0 0",
                     in_ready, out_valid, level);
        end
        checks++;
        if ({out_pc, func3, func7, rs1, rs2, rd, imme, itype, illegal} !== '0) begin
            errors++;
            $display("FAIL reset_slot: got pc %h imm %h it %h ill %b, required all 0",
                     out_pc, imme, itype, illegal);
        end
        checks++;
        if ({x_out_pc, x_imme, x_itype, x_illegal} !== '0) begin
            errors++;
            $display("FAIL reset_slot64: got pc %h imm %h, required 0", x_out_pc, x_imme);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy %b vld %b, required 1 0", in_ready, out_valid);
        end
        tick();
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        push(32'hFFF10093, 32'h100, 9'h001, 5'd2, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b0);
        idle();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || level !== 3'd1) begin
            errors++;
            $display("FAIL addi_latency1: got vld %b lvl %0d, required 0 1", out_valid, level);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL addi_latency2: got vld %b, required 1", out_valid);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int base;
        base = popped;
        out_ready = 1'b1;
        push(32'hFE000EE3, 32'h110, 9'h100, 5'd0, 5'd0, 5'd29, 32'hFFFFFFFC, 1'b0);
        push(32'h00112223, 32'h114, 9'h004, 5'd2, 5'd1, 5'd4, 32'h00000004, 1'b0);
        push(32'h008000EF, 32'h118, 9'h010, 5'd0, 5'd0, 5'd1, 32'h00000008, 1'b0);
        push(32'h12345137, 32'h11C, 9'h040, 5'd0, 5'd0, 5'd2, 32'h12345000, 1'b0);
        idle();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (popped - base != 4) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d outputs, required 4", popped - base);
        end
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++)
            push(32'((k << 20) | (k << 7) | 32'h13), 32'h200 + 32'(4 * k),
                 9'h001, 5'd0, 5'd0, 5'(k), 32'(k), 1'b0);
        fork
            push(32'h00600313, 32'h218, 9'h001, 5'd0, 5'd0, 5'd6, 32'd6, 1'b0);
            begin
                @(negedge clk);
                #1;
                checks++;
                if (level !== 3'd4 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_full: got lvl %0d rdy %b, required 4 0", level, in_ready);
                end
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 32'h204) begin
                    errors++;
                    $display("FAIL bp_slot: got vld %b pc %h, required 1 204", out_valid, out_pc);
                end
                repeat (3) @(negedge clk);
                #1;
                checks++;
                if (level !== 3'd4 || out_pc !== 32'h204 || rd !== 5'd1 || imme !== 32'd1) begin
                    errors++;
                    $display("FAIL bp_hold: got lvl %0d pc %h rd %0d imm %h, required 4 204 1 1",
                             level, out_pc, rd, imme);
                end
                tick();
                out_ready = 1'b1;
            end
        join
        idle();
        drain();
    endtask

    task automatic test_mext();
        out_ready = 1'b1;
        push(32'h022081B3, 32'h300, 9'h000, 5'd0, 5'd0, 5'd3, 32'h0, 1'b1);
        idle();
        wait_valid();
        checks++;
        if ({m_illegal, m_itype, m_rs1, m_rs2, m_rd} !== {1'b0, 9'h008, 5'd1, 5'd2, 5'd3}) begin
            errors++;
            $display("FAIL mul_with_m: got ill %b it %h rs1 %0d rs2 %0d rd %0d, required 0 008 1 2 3",
                     m_illegal, m_itype, m_rs1, m_rs2, m_rd);
        end
        tick();
        push(32'h0000007F, 32'h304, 9'h000, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);
        idle();
        wait_valid();
        checks++;
        if (m_illegal !== 1'b1 || m_itype !== 9'h0) begin
            errors++;
            $display("FAIL bad_opcode_m: got ill %b it %h, required 1 000", m_illegal, m_itype);
        end
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++)
            push(32'((k << 20) | (k << 7) | 32'h13), 32'h400 + 32'(4 * k),
                 9'h001, 5'd0, 5'd0, 5'(k), 32'(k), 1'b0);
        in_instr = 32'h00700393;
        in_pc = 64'h440;
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (level !== 3'd3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_prefill: got lvl %0d vld %b, required 3 1", level, out_valid);
        end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: got lvl %0d vld %b rdy %b, required 0 0 1",
                     level, out_valid, in_ready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (level !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_nostore: got lvl %0d vld %b, required 0 0", level, out_valid);
        end
        tick();
        out_ready = 1'b1;
        push(32'h00900493, 32'h480, 9'h001, 5'd0, 5'd0, 5'd9, 32'd9, 1'b0);
        idle();
        drain();
    endtask

    task automatic test_rv64();
        out_ready = 1'b1;
        push(32'hFF813083, 32'h500, 9'h000, 5'd0, 5'd0, 5'd1, 32'h0, 1'b1);
        idle();
        wait_valid();
        checks++;
        if ({x_illegal, x_itype, x_rs1, x_rd} !== {1'b0, 9'h002, 5'd2, 5'd1}
            || x_imme !== 64'hFFFFFFFFFFFFFFF8 || x_out_pc !== 64'h500) begin
            errors++;
            $display("FAIL rv64_ld: got ill %b it %h rs1 %0d imm %h pc %h, required 0 002 2 fffffffffffffff8 500",
                     x_illegal, x_itype, x_rs1, x_imme, x_out_pc);
        end
        tick();
        push(32'h02809093, 32'h504, 9'h000, 5'd0, 5'd0, 5'd1, 32'h0, 1'b1);
        idle();
        wait_valid();
        checks++;
        if (x_illegal !== 1'b0 || x_itype !== 9'h001 || x_imme !== 64'd40) begin
            errors++;
            $display("FAIL rv64_slli: got ill %b it %h imm %h, required 0 001 28",
                     x_illegal, x_itype, x_imme);
        end
        checks++;
        if (m_illegal !== 1'b1) begin
            errors++;
            $display("FAIL rv32_slli: got ill %b, required 1", m_illegal);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_mext();
        test_flush();
        test_rv64();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
# decode_queue

Buffered, parametrised RV32I/RV64I instruction decode stage. Instructions and their PC are taken from fetch over a valid/ready handshake into a DEPTH-entry FIFO. The head entry is decoded into a registered output slot held under a second valid/ready handshake toward execute. Adds XLEN-wide immediates, optional M-extension acceptance, illegal-instruction detection, flush and occupancy reporting.

## Interface
Parameters:
- XLEN, 32: datapath width, 32 or 64; sets immediate/PC width and legal func3/shift encodings.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- ENABLE_M, 0: 1 makes R-type func7=0000001 legal.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all queued and output-slot contents.
- in_valid  in  1  fetch offers in_instr/in_pc.
- in_ready  out  1  FIFO can accept this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  output slot holds a decoded instruction.
- out_ready  in  1  execute consumes the slot this cycle.
- out_pc  out  XLEN  PC of slot instruction.
- func3  out  3  instr[14:12].
- func7  out  7  instr[31:25].
- rs1, rs2, rd  out  5 each  register addresses.
- imme  out  XLEN  sign-extended immediate.
- itype  out  9  one-hot class: bit0 I, 1 L, 2 S, 3 R, 4 JAL, 5 JALR, 6 LUI, 7 AUIPC, 8 B.
- illegal  out  1  slot instruction is not a legal encoding.
- level  out  $clog2(DEPTH)+1  FIFO occupancy (excludes output slot).

## Operation
- Opcodes instr[6:0]: I 0010011, L 0000011, S 0100011, R 0110011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, B 1100011.
- Push when in_valid & in_ready & !flush. in_ready = (level < DEPTH) & !rst; a same-cycle pop does not raise in_ready.
- Pop FIFO head into output slot when level>0 & (!out_valid | out_ready) & !flush. Slot holds and outputs are stable while out_valid & !out_ready.
- Write/read pointers wrap modulo DEPTH; level = pushes − pops, simultaneous push and pop leave level unchanged.
- rs1 = instr[19:15] for I/L/S/R/JALR/B, else 0. rs2 = instr[24:20] for S/R/B, else 0. rd = instr[11:7] always.
- Immediates, sign bit instr[31] extended to XLEN: I/L/JALR {instr[31:20]}; S {instr[31:25],instr[11:7]}; B {instr[31],instr[7],instr[30:25],instr[11:8],0}; J {instr[31],instr[19:12],instr[20],instr[30:21],0}; U {instr[31:12],12'b0}. Other classes 0.
- illegal=1 when: opcode unmatched; R func7 not 0000000/0100000 (nor 0000001 with ENABLE_M); R func7=0100000 with func3 not 000/101; I func3=001 with instr[31:25]≠0 (XLEN=64: instr[31:26]≠0); I func3=101 with instr[31:25] not 0000000/0100000 (XLEN=64: instr[31:26] not 000000/010000); JALR func3≠000; L func3 ∈ {011,110,111} at XLEN=32, {111} at XLEN=64; S func3>010 at XLEN=32, >011 at XLEN=64; B func3 ∈ {010,011}.
- Illegal instruction still occupies the slot: illegal=1, itype=0, rs1=rs2=0, imme=0, func3/func7/rd/out_pc raw.

## Timing
- Reset: level=0, pointers 0, out_valid=0, in_ready=0 during rst cycle then 1; slot fields out_pc, func3, func7, rs1, rs2, rd, imme, itype, illegal all 0.
- Latency: push at edge T → slot loaded at edge T+1 → out_valid high in cycle T+1 (2nd edge after in_valid sampled if slot free). Sustained throughput 1/cycle with out_ready held high.
- Full: level=DEPTH drops in_ready; in_valid ignored, no overwrite.
- Empty: out_valid falls after consumption when level=0; slot fields hold last values.
- flush: at edge, level=0, pointers 0, out_valid=0; push and pop that cycle suppressed. flush and rst together behave as rst.
- Backpressure: out_ready=0 keeps slot and FIFO contents; fields never change while out_valid & !out_ready.

## Test plan
- Reset, then push addi x1,x2,-1 (0xFFF10093) pc 0x100 → out_valid next cycle, itype=0x001, rs1=2, rd=1, imme=0xFFFFFFFF, illegal=0.
- Push beq with instr 0xFE000EE3 (B, offset −4), sw 0x00112223, jal 0x008000EF, lui 0x12345137 back-to-back, out_ready=1 → one per cycle, imme 0xFFFFFFFC, 0x4, 0x8, 0x12345000.
- out_ready=0, push DEPTH+1 instrs → in_ready low at level=DEPTH, extra held by source; release → order preserved, no loss.
- mul 0x022081B3 with ENABLE_M=0 → illegal=1, itype=0; ENABLE_M=1 → illegal=0, itype=0x008; opcode 0x7F → illegal=1.
- Fill 3 entries, assert flush with in_valid=1 → next cycle level=0, out_valid=0, flushed-cycle instr not stored.
- XLEN=64: ld 0xFF813083 → legal, imme=0xFFFFFFFFFFFFFFF8; slli shamt 40 (0x02809093) → legal; same at XLEN=32 → illegal.
